// File: rtl/int_ctrl_if.sv
// CPU-side bus of the interrupt controller: external request lines, eret,
// configuration writes, and the interrupt/cause/status outputs.
interface int_ctrl_if #(
   parameter int N_SRC = 4
) ();
   logic [N_SRC-1:0] irq;
   logic             eret;
   logic             cfg_we;
   logic             cfg_sel;
   logic [31:0]      cfg_wdata;
   logic             int_o;
   logic [2:0]       cause;
   logic             in_service;
   logic [31:0]      status;

   modport master (
      output irq, eret, cfg_we, cfg_sel, cfg_wdata,
      input  int_o, cause, in_service, status
   );

   modport slave (
      input  irq, eret, cfg_we, cfg_sel, cfg_wdata,
      output int_o, cause, in_service, status
   );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises irq lines, latches rising edges as pending,
// masks and prioritises them, and pulses int_o once per handler until eret.
module int_ctrl #(
   parameter int N_SRC = 4
) (
   input logic        clk,
   input logic        reset,
   int_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, FIRE, SERVE} state_t;

   state_t           state;
   logic [N_SRC-1:0] s1, s2, d;
   logic [N_SRC-1:0] pending, mask;
   logic             ie;
   logic             int_q;
   logic             busy;
   logic [2:0]       cause_q;

   logic [N_SRC-1:0] rise, eligible, win_oh, take_vec, cfg_clr;
   logic [2:0]       win;
   logic             found, take;
   logic [31:0]      status_w;
   logic             unused_wdata;

   assign rise     = s2 & ~d;
   assign eligible = pending & mask;

   // Lowest index wins.
   always_comb begin
      win    = '0;
      win_oh = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (eligible[i] && !found) begin
            win       = 3'(i);
            win_oh[i] = 1'b1;
            found     = 1'b1;
         end
      end
   end

   assign take     = (state == IDLE) && ie && (|eligible) && !bus.eret;
   assign take_vec = take ? win_oh : '0;
   assign cfg_clr  = (bus.cfg_we && bus.cfg_sel) ? bus.cfg_wdata[16 +: N_SRC] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
         d  <= '0;
      end else begin
         s1 <= bus.irq;
         s2 <= s1;
         d  <= s2;
      end
   end

   // A new edge is OR'd in after the clears so it is never lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
         mask    <= '0;
         ie      <= 1'b0;
      end else begin
         pending <= (pending & ~take_vec & ~cfg_clr) | rise;
         if (bus.cfg_we && !bus.cfg_sel) begin
            ie   <= bus.cfg_wdata[0];
            mask <= bus.cfg_wdata[8 +: N_SRC];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         int_q   <= 1'b0;
         busy    <= 1'b0;
         cause_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  state   <= FIRE;
                  int_q   <= 1'b1;
                  busy    <= 1'b1;
                  cause_q <= win;
               end
            end
            FIRE: begin
               state <= SERVE;
               int_q <= 1'b0;
            end
            SERVE: begin
               if (bus.eret) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               int_q <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      status_w              = '0;
      status_w[16 +: N_SRC] = pending;
      status_w[8 +: N_SRC]  = mask;
      status_w[1]           = busy;
      status_w[0]           = ie;
   end

   assign unused_wdata   = ^bus.cfg_wdata;
   assign bus.int_o      = int_q;
   assign bus.cause      = cause_q;
   assign bus.in_service = busy;
   assign bus.status     = status_w;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: latency, priority, masking, nesting block,
// simultaneous set/clear, eret in IDLE and asynchronous reset.
module tb_int_ctrl;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   int_ctrl_if #(.N_SRC(4)) bus ();

   int_ctrl #(.N_SRC(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input logic sel, input logic [31:0] data);
      bus.cfg_we    = 1'b1;
      bus.cfg_sel   = sel;
      bus.cfg_wdata = data;
      tick();
      bus.cfg_we    = 1'b0;
      bus.cfg_sel   = 1'b0;
      bus.cfg_wdata = '0;
   endtask

   task automatic do_eret();
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      reset         = 1'b1;
      bus.irq       = '0;
      bus.eret      = 1'b0;
      bus.cfg_we    = 1'b0;
      bus.cfg_sel   = 1'b0;
      bus.cfg_wdata = '0;
      tick();
      tick();
      reset = 1'b0;

      chk("rst_int",    32'(bus.int_o), 32'd0);
      chk("rst_cause",  32'(bus.cause), 32'd0);
      chk("rst_serv",   32'(bus.in_service), 32'd0);
      chk("rst_status", bus.status, 32'h0000_0000);

      // Basic latency: 4 edges from the first sampling edge.
      cfg_write(1'b0, 32'h0000_0101);
      chk("b_status_cfg", bus.status, 32'h0000_0101);
      bus.irq = 4'b0001;
      tick();
      bus.irq = '0;
      chk("b_int_k", 32'(bus.int_o), 32'd0);
      tick();
      chk("b_int_k1", 32'(bus.int_o), 32'd0);
      tick();
      chk("b_int_k2", 32'(bus.int_o), 32'd0);
      chk("b_pend_k2", bus.status, 32'h0001_0101);
      tick();
      chk("b_int_k3", 32'(bus.int_o), 32'd1);
      chk("b_cause", 32'(bus.cause), 32'd0);
      chk("b_serv", 32'(bus.in_service), 32'd1);
      chk("b_status_k3", bus.status, 32'h0000_0103);
      tick();
      chk("b_int_k4", 32'(bus.int_o), 32'd0);
      chk("b_serv_k4", 32'(bus.in_service), 32'd1);
      do_eret();
      chk("b_serv_eret", 32'(bus.in_service), 32'd0);

      // Priority: sources 3 and 1 together, 1 wins, 3 follows after eret.
      cfg_write(1'b0, 32'h0000_0F01);
      bus.irq = 4'b1010;
      tick();
      bus.irq = '0;
      tick();
      tick();
      chk("p_pend", bus.status, 32'h000A_0F01);
      tick();
      chk("p_int1", 32'(bus.int_o), 32'd1);
      chk("p_cause1", 32'(bus.cause), 32'd1);
      chk("p_status1", bus.status, 32'h0008_0F03);
      tick();
      chk("p_int1_end", 32'(bus.int_o), 32'd0);
      do_eret();
      chk("p_int_eret", 32'(bus.int_o), 32'd0);
      chk("p_serv_eret", 32'(bus.in_service), 32'd0);
      tick();
      chk("p_int2", 32'(bus.int_o), 32'd1);
      chk("p_cause2", 32'(bus.cause), 32'd3);
      tick();
      chk("p_int2_end", 32'(bus.int_o), 32'd0);
      chk("p_status2", bus.status, 32'h0000_0F03);
      do_eret();

      // Masking: pending but masked source never fires until unmasked.
      cfg_write(1'b0, 32'h0000_0001);
      bus.irq = 4'b0100;
      tick();
      bus.irq = '0;
      for (int i = 0; i < 5; i++) begin
         chk("m_noint", 32'(bus.int_o), 32'd0);
         tick();
      end
      chk("m_status", bus.status, 32'h0004_0001);
      cfg_write(1'b0, 32'h0000_0401);
      chk("m_int_cfgedge", 32'(bus.int_o), 32'd0);
      tick();
      chk("m_int", 32'(bus.int_o), 32'd1);
      chk("m_cause", 32'(bus.cause), 32'd2);
      tick();
      chk("m_int_end", 32'(bus.int_o), 32'd0);

      // Nesting block: edge during SERVE stays pending; clear it before eret.
      bus.irq = 4'b0001;
      tick();
      bus.irq = '0;
      for (int i = 0; i < 4; i++) begin
         chk("n_noint", 32'(bus.int_o), 32'd0);
         tick();
      end
      chk("n_status", bus.status, 32'h0001_0403);
      cfg_write(1'b1, 32'h0001_0000);
      chk("n_cleared", bus.status, 32'h0000_0403);
      do_eret();
      for (int i = 0; i < 4; i++) begin
         chk("n_noint_after", 32'(bus.int_o), 32'd0);
         tick();
      end
      chk("n_serv", 32'(bus.in_service), 32'd0);

      // Simultaneous: pending-clear in the same cycle as a new edge keeps it.
      cfg_write(1'b0, 32'h0000_0001);
      bus.irq = 4'b0010;
      tick();
      bus.irq = '0;
      tick();
      cfg_write(1'b1, 32'h0002_0000);
      chk("s_setwins", bus.status, 32'h0002_0001);
      cfg_write(1'b1, 32'h0002_0000);
      chk("s_clear", bus.status, 32'h0000_0001);
      do_eret();
      chk("s_eret_idle_int", 32'(bus.int_o), 32'd0);
      chk("s_eret_idle_serv", 32'(bus.in_service), 32'd0);
      chk("s_eret_idle_stat", bus.status, 32'h0000_0001);

      // Asynchronous reset while int_o is high.
      cfg_write(1'b0, 32'h0000_0101);
      bus.irq = 4'b0001;
      tick();
      bus.irq = '0;
      tick();
      tick();
      tick();
      chk("r_int_pre", 32'(bus.int_o), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("r_int_async", 32'(bus.int_o), 32'd0);
      chk("r_serv_async", 32'(bus.in_service), 32'd0);
      chk("r_status_async", bus.status, 32'h0000_0000);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("r_noint", 32'(bus.int_o), 32'd0);
         tick();
      end
      chk("r_cause", 32'(bus.cause), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
